// File: rtl/anton_neopixel_serializer.sv
// anton_neopixel_serializer
//
// Bit-timing stage of the neopixel controller, clocked at 10 MHz. It takes
// pixel bytes from the pixel buffer over a valid/ready stream and emits the
// WS2812 one-wire waveform on neoData, MSB first. Each bit occupies a fixed
// BIT_CYCLES slot: a high phase of T1H_CYCLES ('1') or T0H_CYCLES ('0'),
// followed by a low phase that pads the slot out to BIT_CYCLES.
//
// After the byte flagged with byteLast, or when the producer starves at a
// byte boundary (underrun), the line is held low for RESET_CYCLES so the
// LEDs latch their colours. frameDone pulses on the last latch cycle.
//
// The next byte of a frame is accepted on the final low cycle of bit 0 of
// the current byte, so consecutive bytes produce back-to-back bit slots with
// no idle gap between them.
//
// Optional feature, enabled by defining NEOPIXEL_FRAME_COUNT_EN:
//   adds output frameCount[15:0], a wrapping count of completed frames
//   (every frameDone pulse, including frames ended by an underrun).
//
// Parameter legality: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES.

module anton_neopixel_serializer #(
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int BIT_CYCLES   = 12,
  parameter int RESET_CYCLES = 500
) (
  input  logic        clk10mhz,
  input  logic        reset,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  input  logic        byteLast,
  output logic        byteReady,
  output logic        neoData,
  output logic        neoState,
  output logic        frameDone,
  output logic        underrun
`ifdef NEOPIXEL_FRAME_COUNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  // Phase counter is sized for the longer of a bit slot and the latch period,
  // so it can never wrap before a terminal count is reached.
  localparam int MAX_CYCLES = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Terminal counts (counter starts at 0 on every state entry).
  localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW0_LAST  = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW1_LAST  = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic             last_flag;
  logic             last_nxt;
  logic             neo_data_r;
  logic             neo_state_r;

  logic             cur_bit;
  logic             high_done;
  logic             slot_end;
  logic             byte_end;
  logic             ready_int;
  logic             accept;
  logic             frame_done;
  logic             underrun_int;

  // Phase-end decode for the bit currently being transmitted (always the MSB
  // of the shift register; it only shifts when the next slot starts).
  always_comb begin
    cur_bit   = shift_reg[7];
    high_done = (state == ST_HIGH) && (cnt == (cur_bit ? T1H_LAST : T0H_LAST));
    slot_end  = (state == ST_LOW)  && (cnt == (cur_bit ? LOW1_LAST : LOW0_LAST));
    byte_end  = slot_end && (bit_idx == 3'd0);
  end

  // Handshake and status pulses. The reset gate keeps byteReady low during
  // the reset cycle so no byte is consumed while the block is being cleared.
  always_comb begin
    ready_int    = !reset && ((state == ST_IDLE) || (byte_end && !last_flag));
    accept       = ready_int && byteValid;
    frame_done   = !reset && (state == ST_LATCH) && (cnt == LATCH_LAST);
    underrun_int = !reset && byte_end && !last_flag && !byteValid;
  end

  // Next-state, counter and shifter logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    shift_nxt   = shift_reg;
    bit_idx_nxt = bit_idx;
    last_nxt    = last_flag;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          shift_nxt   = byteData;
          bit_idx_nxt = 3'd7;
          last_nxt    = byteLast;
          state_nxt   = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (high_done) begin
          cnt_nxt   = '0;
          state_nxt = ST_LOW;
        end
      end

      ST_LOW: begin
        if (slot_end) begin
          cnt_nxt = '0;
          if (bit_idx != 3'd0) begin
            bit_idx_nxt = bit_idx - 3'd1;
            shift_nxt   = {shift_reg[6:0], 1'b0};
            state_nxt   = ST_HIGH;
          end else if (accept) begin
            // Next byte of the same frame: start its first slot immediately.
            shift_nxt   = byteData;
            bit_idx_nxt = 3'd7;
            last_nxt    = byteLast;
            state_nxt   = ST_HIGH;
          end else begin
            // Either the frame ended or the producer starved; both latch.
            state_nxt = ST_LATCH;
          end
        end
      end

      ST_LATCH: begin
        if (cnt == LATCH_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state and registered line outputs; reset aborts any bit or latch.
  always_ff @(posedge clk10mhz) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      last_flag   <= 1'b0;
      neo_data_r  <= 1'b0;
      neo_state_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      last_flag   <= last_nxt;
      neo_data_r  <= (state_nxt == ST_HIGH);
      neo_state_r <= (state_nxt == ST_LATCH);
    end
  end

  // Pixel shift register: data path only, always loaded before it is used.
  always_ff @(posedge clk10mhz) begin
    shift_reg <= shift_nxt;
  end

  assign byteReady = ready_int;
  assign neoData   = neo_data_r;
  assign neoState  = neo_state_r;
  assign frameDone = frame_done;
  assign underrun  = underrun_int;

`ifdef NEOPIXEL_FRAME_COUNT_EN
  logic [15:0] frame_count;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk10mhz) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign frameCount = frame_count;
`endif

endmodule

// File: tb/tb_anton_neopixel_serializer.sv
// Testbench for anton_neopixel_serializer.
// The reference model derives every expected output per cycle from the
// frame contents: slot index -> byte/bit/phase -> line level, plus the
// latch window and handshake points.

module tb_anton_neopixel_serializer;

  localparam int T0H  = 4;
  localparam int T1H  = 8;
  localparam int BITC = 12;
  localparam int RSTC = 500;
  localparam int SLOT = 8 * BITC;

  logic       clk10mhz = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byteData = 8'd0;
  logic       byteValid = 1'b0;
  logic       byteLast = 1'b0;
  logic       byteReady;
  logic       neoData;
  logic       neoState;
  logic       frameDone;
  logic       underrun;
`ifdef NEOPIXEL_FRAME_COUNT_EN
  logic [15:0] frameCount;
`endif

  int checks = 0;
  int errors = 0;
  int fc_model = 0;

  // Current frame contents for the model and the producer.
  logic [7:0] fb [0:7];
  int         fn = 0;

  always #50 clk10mhz = ~clk10mhz;

  anton_neopixel_serializer #(
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .BIT_CYCLES  (BITC),
    .RESET_CYCLES(RSTC)
  ) dut (
    .clk10mhz (clk10mhz),
    .reset    (reset),
    .byteData (byteData),
    .byteValid(byteValid),
    .byteLast (byteLast),
    .byteReady(byteReady),
    .neoData  (neoData),
    .neoState (neoState),
    .frameDone(frameDone),
    .underrun (underrun)
`ifdef NEOPIXEL_FRAME_COUNT_EN
    ,
    .frameCount(frameCount)
`endif
  );

  // Runs one frame of fn bytes from fb starting with an IDLE cycle (k=0).
  // um: producer stops after the last byte without byteLast (underrun).
  // keep: during latch, present nb/nl as the first byte of the next frame.
  task automatic run_frame(input bit um, input bit keep, input logic [7:0] nb,
                           input bit nl, input string name);
    int n;
    int d;
    int ptr;
    int p;
    int bi;
    int bitn;
    int ph;
    logic e_data, e_state, e_fd, e_ur, e_rdy;
    n   = fn;
    d   = n * SLOT;
    ptr = 0;
    for (int k = 0; k <= d + RSTC; k++) begin
      e_data = 1'b0; e_state = 1'b0; e_fd = 1'b0; e_ur = 1'b0; e_rdy = 1'b0;
      if (k == 0) begin
        e_rdy = 1'b1;
      end else if (k <= d) begin
        p      = k - 1;
        bi     = p / SLOT;
        bitn   = 7 - ((p % SLOT) / BITC);
        ph     = p % BITC;
        e_data = (ph < (fb[bi][bitn] ? T1H : T0H));
        e_rdy  = (ph == BITC - 1) && (bitn == 0) && ((bi < n - 1) || um);
        e_ur   = um && (k == d);
      end else begin
        e_state = 1'b1;
        e_fd    = (k == d + RSTC);
      end

      if (ptr < n) begin
        byteValid = 1'b1;
        byteData  = fb[ptr];
        byteLast  = !um && (ptr == n - 1);
      end else if (keep && k > d) begin
        byteValid = 1'b1;
        byteData  = nb;
        byteLast  = nl;
      end else begin
        byteValid = 1'b0;
        byteData  = 8'($urandom);
        byteLast  = 1'($urandom);
      end
      #1;
      checks++;
      if ({neoData, neoState, frameDone, underrun, byteReady} !==
          {e_data, e_state, e_fd, e_ur, e_rdy}) begin
        errors++;
        $display("FAIL %s cycle %0d: data/state/done/underrun/ready got %b%b%b%b%b expected %b%b%b%b%b",
                 name, k, neoData, neoState, frameDone, underrun, byteReady,
                 e_data, e_state, e_fd, e_ur, e_rdy);
      end
      if (byteValid && e_rdy) ptr++;
      if (e_fd) fc_model++;
      @(posedge clk10mhz); #1;
    end
`ifdef NEOPIXEL_FRAME_COUNT_EN
    checks++;
    if (frameCount !== 16'(fc_model)) begin
      errors++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, frameCount, fc_model);
    end
`endif
  endtask

  task automatic test_reset();
    byteValid = 1'b1;
    byteData  = 8'hFF;
    byteLast  = 1'b1;
    #1;
    checks++;
    if ({byteReady, frameDone, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_cycle: ready/done/underrun got %b%b%b expected 000",
               byteReady, frameDone, underrun);
    end
    @(posedge clk10mhz); #1;
    reset     = 1'b0;
    byteValid = 1'b0;
    fc_model  = 0;
    #1;
    checks++;
    if ({neoData, neoState, frameDone, underrun, byteReady} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_idle: data/state/done/underrun/ready got %b%b%b%b%b expected 00001",
               neoData, neoState, frameDone, underrun, byteReady);
    end
`ifdef NEOPIXEL_FRAME_COUNT_EN
    checks++;
    if (frameCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d expected 0", frameCount);
    end
`endif
    @(posedge clk10mhz); #1;
  endtask

  task automatic test_single_byte();
    fn = 1; fb[0] = 8'hA5;
    run_frame(1'b0, 1'b0, 8'h00, 1'b0, "single_a5");
  endtask

  task automatic test_back_to_back();
    fn = 3; fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h81;
    run_frame(1'b0, 1'b0, 8'h00, 1'b0, "back_to_back");
  endtask

  task automatic test_underrun();
    fn = 2; fb[0] = 8'($urandom); fb[1] = 8'($urandom);
    run_frame(1'b1, 1'b0, 8'h00, 1'b0, "underrun");
  endtask

  task automatic test_reset_mid_bit();
    // Handshake a 0xFF byte, then reset on the 5th high cycle of bit 7.
    byteValid = 1'b1; byteData = 8'hFF; byteLast = 1'b1;
    #1;
    checks++;
    if (byteReady !== 1'b1) begin
      errors++;
      $display("FAIL midbit_handshake: ready got %b expected 1", byteReady);
    end
    @(posedge clk10mhz); #1;
    byteValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (neoData !== 1'b1) begin
        errors++;
        $display("FAIL midbit_high cycle %0d: neoData got %b expected 1", k, neoData);
      end
      @(posedge clk10mhz); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({byteReady, frameDone, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL midbit_reset_cycle: ready/done/underrun got %b%b%b expected 000",
               byteReady, frameDone, underrun);
    end
    @(posedge clk10mhz); #1;
    reset    = 1'b0;
    fc_model = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({neoData, neoState, byteReady} !== 3'b001) begin
        errors++;
        $display("FAIL midbit_after_reset %0d: data/state/ready got %b%b%b expected 001",
                 k, neoData, neoState, byteReady);
      end
      @(posedge clk10mhz); #1;
    end
  endtask

  task automatic test_latch_holdoff();
    logic [7:0] nb;
    nb = 8'($urandom);
    fn = 1; fb[0] = 8'($urandom);
    run_frame(1'b0, 1'b1, nb, 1'b1, "holdoff_first");
    fn = 1; fb[0] = nb;
    run_frame(1'b0, 1'b0, 8'h00, 1'b0, "holdoff_second");
  endtask

  task automatic test_random_frames();
    int nl2;
    bit um, um2, keep, nlast;
    logic [7:0] nb;
    fn = $urandom_range(1, 3);
    um = 1'($urandom_range(0, 1));
    for (int i = 0; i < fn; i++) fb[i] = 8'($urandom);
    for (int f = 0; f < 5; f++) begin
      nl2   = $urandom_range(1, 3);
      um2   = 1'($urandom_range(0, 1));
      keep  = (f < 4) && ($urandom_range(0, 1) == 1);
      nb    = 8'($urandom);
      nlast = (nl2 == 1) && !um2;
      run_frame(um, keep, nb, nlast, "random");
      fn = nl2;
      um = um2;
      fb[0] = nb;
      for (int i = 1; i < fn; i++) fb[i] = 8'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk10mhz);
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_bit();
    test_latch_holdoff();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
